fifo_wr_ptr_full: RTL and testbench

Write-domain pointer and full-flag controller for the team's asynchronous FIFO. It sits directly upstream of the two-flop pointer synchronizer. It drives its registered Gray write pointer into the synchronizer toward the read domain, and it consumes the read pointer already synchronized into this domain. It produces the dual-port RAM write address and enable, the full and almost-full flags, a fill level and a sticky overflow flag.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/gray_bin_ptr.sv | 37 +++
 rtl/fifo_wr_ptr_full.sv | 71 +++++++
 tb/tb_fifo_wr_ptr_full.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer helpers for the async FIFO read/write controllers
// Contents:
//   ptr_t        wide pointer carrier; callers zero-extend into it and truncate back
//   bin2gray     binary -> reflected Gray code
//   gray2bin     Gray -> binary, XOR prefix from the MSB down
//   ADDR_SIZE    RAM address width for the default 8-entry FIFO
package fifo_pkg;
    localparam int PTR_W = 32;
    localparam int DEF_MEM_DEPTH = 8;
    localparam int DEF_PTR_SIZE = $clog2(DEF_MEM_DEPTH) + 1;
    localparam int ADDR_SIZE = DEF_PTR_SIZE - 1;

    typedef logic [PTR_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero upper bits stay zero through the prefix, so narrow pointers convert correctly.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[PTR_W-1] = gray[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) bin[i] = bin[i+1] ^ gray[i];
        return bin;
    endfunction
endpackage

// File: rtl/gray_bin_ptr.sv
// gray_bin_ptr: registered binary + Gray pointer pair with increment enable
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   inc          advance the pointer at this edge
//   addr         low W-1 bits of the registered binary pointer (RAM address)
//   gray         registered Gray pointer; one bit changes per edge, safe to synchronize
//   bin_nxt      binary value the pointer takes at the next edge
//   gray_nxt     Gray value the pointer takes at the next edge
module gray_bin_ptr
    import fifo_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-2:0] addr,
    output logic [W-1:0] gray,
    output logic [W-1:0] bin_nxt,
    output logic [W-1:0] gray_nxt
);
    logic [W-1:0] bin;

    assign addr     = bin[W-2:0];
    assign bin_nxt  = bin + W'(inc);
    assign gray_nxt = W'(bin2gray(ptr_t'(bin_nxt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_nxt;
            gray <= gray_nxt;
        end
    end
endmodule

// File: rtl/fifo_wr_ptr_full.sv
// fifo_wr_ptr_full: write-side pointer, full/almost-full and fill level for the async FIFO
// Ports:
//   CLK, RST      write clock, asynchronous active-low reset
//   W_INC         write request
//   RD_PTR_SYNC   Gray read pointer already synchronized into CLK
//   CLR_OVF       clears OVERFLOW (a simultaneous overflow still sets it)
//   W_EN          RAM write enable, W_INC & ~FULL
//   W_ADDR        RAM write address
//   WR_PTR        registered Gray write pointer toward the synchronizer
//   FULL          registered full flag
//   ALMOST_FULL   registered, FILL_LEVEL >= AFULL_THRESH
//   FILL_LEVEL    registered occupancy 0..MEM_DEPTH as seen from the write side
//   OVERFLOW      sticky, write attempted while FULL
module fifo_wr_ptr_full
    import fifo_pkg::*;
#(
    parameter int MEM_DEPTH    = 8,
    parameter int PTR_SIZE     = $clog2(MEM_DEPTH) + 1,
    parameter int AFULL_THRESH = MEM_DEPTH - 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                W_INC,
    input  logic [PTR_SIZE-1:0] RD_PTR_SYNC,
    input  logic                CLR_OVF,
    output logic                W_EN,
    output logic [PTR_SIZE-2:0] W_ADDR,
    output logic [PTR_SIZE-1:0] WR_PTR,
    output logic                FULL,
    output logic                ALMOST_FULL,
    output logic [PTR_SIZE-1:0] FILL_LEVEL,
    output logic                OVERFLOW
);
    logic [PTR_SIZE-1:0] wbin_nxt;
    logic [PTR_SIZE-1:0] gray_nxt;
    logic [PTR_SIZE-1:0] rd_full;
    logic [PTR_SIZE-1:0] rbin;
    logic [PTR_SIZE-1:0] level_nxt;

    assign W_EN = W_INC & ~FULL;

    gray_bin_ptr #(.W(PTR_SIZE)) u_ptr (
        .clk      (CLK),
        .rst_n    (RST),
        .inc      (W_EN),
        .addr     (W_ADDR),
        .gray     (WR_PTR),
        .bin_nxt  (wbin_nxt),
        .gray_nxt (gray_nxt)
    );

    // In Gray code, "one lap ahead" of the read pointer means the top two bits inverted.
    assign rd_full   = {~RD_PTR_SYNC[PTR_SIZE-1 -: 2], RD_PTR_SYNC[PTR_SIZE-3:0]};
    assign rbin      = PTR_SIZE'(gray2bin(ptr_t'(RD_PTR_SYNC)));
    assign level_nxt = wbin_nxt - rbin;

    // Flags use the next pointer so they assert on the edge that accepts the filling write.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            FULL        <= 1'b0;
            ALMOST_FULL <= 1'b0;
            FILL_LEVEL  <= '0;
            OVERFLOW    <= 1'b0;
        end else begin
            FULL        <= gray_nxt == rd_full;
            ALMOST_FULL <= level_nxt >= PTR_SIZE'(AFULL_THRESH);
            FILL_LEVEL  <= level_nxt;
            OVERFLOW    <= (W_INC & FULL) | (OVERFLOW & ~CLR_OVF);
        end
    end
endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// tb_fifo_wr_ptr_full: scoreboard bench for the write-side FIFO controller
module tb_fifo_wr_ptr_full;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       W_INC = 1'b0;
    logic       CLR_OVF = 1'b0;
    logic [3:0] RD_PTR_SYNC = 4'h0;
    logic       W_EN;
    logic [2:0] W_ADDR;
    logic [3:0] WR_PTR;
    logic       FULL;
    logic       ALMOST_FULL;
    logic [3:0] FILL_LEVEL;
    logic       OVERFLOW;
    logic [13:0] got;
    logic [13:0] exp;
    logic [13:0] sb[$];
    int compared = 0;
    int mismatched = 0;
    logic [3:0] m_wbin = 4'h0;
    logic [3:0] m_lvl = 4'h0;
    logic       m_full = 1'b0;
    logic       m_af = 1'b0;
    logic       m_ovf = 1'b0;

    fifo_wr_ptr_full #(.MEM_DEPTH(8), .PTR_SIZE(4), .AFULL_THRESH(6)) dut (
        .CLK(CLK), .RST(RST), .W_INC(W_INC), .RD_PTR_SYNC(RD_PTR_SYNC), .CLR_OVF(CLR_OVF),
        .W_EN(W_EN), .W_ADDR(W_ADDR), .WR_PTR(WR_PTR), .FULL(FULL),
        .ALMOST_FULL(ALMOST_FULL), .FILL_LEVEL(FILL_LEVEL), .OVERFLOW(OVERFLOW)
    );

    assign got = {WR_PTR, W_ADDR, FULL, ALMOST_FULL, FILL_LEVEL, OVERFLOW};

    always #5 CLK = ~CLK;

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Occupancy-based reference: full means exactly 8 entries outstanding.
    task automatic model_step();
        logic [3:0] nb;
        logic [3:0] lv;
        nb = m_wbin + {3'b0, W_INC & ~m_full};
        if (W_INC && m_full) m_ovf = 1'b1;
        else if (CLR_OVF) m_ovf = 1'b0;
        lv = nb - g2b(RD_PTR_SYNC);
        m_wbin = nb;
        m_lvl = lv;
        m_full = (lv == 4'd8);
        m_af = (lv >= 4'd6);
        sb.push_back({b2g(nb), nb[2:0], m_full, m_af, m_lvl, m_ovf});
    endtask

    task automatic drive(input logic w, input logic c);
        W_INC = w;
        CLR_OVF = c;
        model_step();
        @(posedge CLK);
        #1;
        W_INC = 1'b0;
        CLR_OVF = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        compared++;
        if (got !== 14'h0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h expected %h", got, 14'h0);
        end
        compared++;
        if (W_EN !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_w_en: got %b expected 0", W_EN);
        end
        #10 RST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_fill();
        logic [3:0] seq[8];
        seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (W_ADDR !== 3'(i)) begin
                mismatched++;
                $display("FAIL fill_addr[%0d]: got %0d expected %0d", i, W_ADDR, i);
            end
            drive(1'b1, 1'b0);
            exp = sb.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL fill_sb[%0d]: got %h expected %h", i, got, exp);
            end
            compared++;
            if (WR_PTR !== seq[i] || ALMOST_FULL !== (i >= 5)) begin
                mismatched++;
                $display("FAIL fill_ptr[%0d]: got ptr %h af %b expected ptr %h af %b",
                         i, WR_PTR, ALMOST_FULL, seq[i], i >= 5);
            end
        end
        compared++;
        if (FULL !== 1'b1 || FILL_LEVEL !== 4'd8) begin
            mismatched++;
            $display("FAIL fill_full: got full %b level %0d expected full 1 level 8", FULL, FILL_LEVEL);
        end
    endtask

    task automatic test_overflow();
        W_INC = 1'b1;
        #1;
        compared++;
        if (W_EN !== 1'b0) begin
            mismatched++;
            $display("FAIL ovf_w_en: got %b expected 0", W_EN);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0);
            exp = sb.pop_front();
            compared++;
            if (got !== exp || WR_PTR !== 4'hC || OVERFLOW !== 1'b1) begin
                mismatched++;
                $display("FAIL ovf_hold[%0d]: got %h expected %h", i, got, exp);
            end
        end
        drive(1'b0, 1'b0);
        exp = sb.pop_front();
        compared++;
        if (got !== exp || OVERFLOW !== 1'b1) begin
            mismatched++;
            $display("FAIL ovf_sticky: got %h expected %h", got, exp);
        end
        drive(1'b0, 1'b1);
        exp = sb.pop_front();
        compared++;
        if (got !== exp || OVERFLOW !== 1'b0) begin
            mismatched++;
            $display("FAIL ovf_clear: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_read_refill();
        RD_PTR_SYNC = 4'h1;
        drive(1'b0, 1'b0);
        exp = sb.pop_front();
        compared++;
        if (got !== exp || FULL !== 1'b0 || FILL_LEVEL !== 4'd7) begin
            mismatched++;
            $display("FAIL read_drop: got %h expected %h", got, exp);
        end
        W_INC = 1'b1;
        #1;
        compared++;
        if (W_EN !== 1'b1) begin
            mismatched++;
            $display("FAIL refill_w_en: got %b expected 1", W_EN);
        end
        drive(1'b1, 1'b0);
        exp = sb.pop_front();
        compared++;
        if (got !== exp || FULL !== 1'b1 || WR_PTR !== 4'hD) begin
            mismatched++;
            $display("FAIL refill: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] prev;
        RD_PTR_SYNC = b2g(m_wbin);
        drive(1'b0, 1'b0);
        exp = sb.pop_front();
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL wrap_drain: got %h expected %h", got, exp);
        end
        prev = b2g(m_wbin);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0);
            exp = sb.pop_front();
            compared++;
            if (got !== exp || FULL !== 1'b0 || $countones(WR_PTR ^ prev) != 1) begin
                mismatched++;
                $display("FAIL wrap_write[%0d]: got %h prev ptr %h expected %h", i, got, prev, exp);
            end
            prev = WR_PTR;
            RD_PTR_SYNC = b2g(g2b(RD_PTR_SYNC) + 4'd1);
            drive(1'b0, 1'b0);
            exp = sb.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL wrap_read[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0);
            exp = sb.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL burst[%0d]: got %h expected %h", i, got, exp);
            end
        end
        W_INC = 1'b1;
        #3 RST = 1'b0;
        RD_PTR_SYNC = 4'h0;
        #1;
        compared++;
        if (got !== 14'h0) begin
            mismatched++;
            $display("FAIL async_reset: got %h expected %h", got, 14'h0);
        end
        W_INC = 1'b0;
        m_wbin = 4'h0;
        m_lvl = 4'h0;
        m_full = 1'b0;
        m_af = 1'b0;
        m_ovf = 1'b0;
        @(posedge CLK);
        #3 RST = 1'b1;
        compared++;
        if (W_ADDR !== 3'd0) begin
            mismatched++;
            $display("FAIL resume_addr0: got %0d expected 0", W_ADDR);
        end
        drive(1'b1, 1'b0);
        exp = sb.pop_front();
        compared++;
        if (got !== exp || W_ADDR !== 3'd1) begin
            mismatched++;
            $display("FAIL resume_write: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_set_wins();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0);
            exp = sb.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL refill2[%0d]: got %h expected %h", i, got, exp);
            end
        end
        compared++;
        if (FULL !== 1'b1) begin
            mismatched++;
            $display("FAIL refill2_full: got %b expected 1", FULL);
        end
        drive(1'b1, 1'b1);
        exp = sb.pop_front();
        compared++;
        if (got !== exp || OVERFLOW !== 1'b1) begin
            mismatched++;
            $display("FAIL set_wins: got %h expected %h", got, exp);
        end
        drive(1'b0, 1'b1);
        exp = sb.pop_front();
        compared++;
        if (got !== exp || OVERFLOW !== 1'b0) begin
            mismatched++;
            $display("FAIL set_wins_clear: got %h expected %h", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_read_refill();
        test_wrap();
        test_async_reset();
        test_set_wins();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
